// File: rtl/adder16_s_pkg.sv
// Shared constants for the 16-bit two-stage pipelined adder.
// Datapath is split into 4-bit carry-lookahead nibbles rippled by carry.
package adder16_s_pkg;

  localparam int unsigned ADD_W    = 16;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned NIB_N    = ADD_W / NIB_W;

endpackage

// File: rtl/adder16_s_adder4.sv
// 4-bit carry-lookahead adder slice; purely combinational, no flow control.
// All four carries are formed directly from generate/propagate terms.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p    = a ^ b;
  assign w_g    = a & b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule

// File: rtl/adder16_s.sv
// 16-bit pipelined adder: operands registered, then {cout,sum} registered; 2-edge latency.
// Accepts one operand set per cycle, never stalls; reset clears both stages immediately.
module adder16_s
  import adder16_s_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ADD_W-1:0] x,
  input  logic [ADD_W-1:0] y,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  logic [ADD_W-1:0] r_x;
  logic [ADD_W-1:0] r_y;
  logic             r_cin;
  logic [ADD_W-1:0] w_sum;
  logic [NIB_N:0]   w_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cin <= 1'b0;
    end else begin
      r_x   <= x;
      r_y   <= y;
      r_cin <= cin;
    end
  end

  // Nibble slices chained low to high through w_c.
  assign w_c[0] = r_cin;

  for (genvar i = 0; i < int'(NIB_N); i++) begin : g_nib
    adder4 u_adder4 (
      .a  (r_x[i*NIB_W +: NIB_W]),
      .b  (r_y[i*NIB_W +: NIB_W]),
      .ci (w_c[i]),
      .s  (w_sum[i*NIB_W +: NIB_W]),
      .co (w_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= w_sum;
      cout <= w_c[NIB_N];
    end
  end

endmodule

// File: tb/tb_adder16_s.sv
// Directed bench for adder16_s: reset, corner sums, streaming ramp, async reset, glitches.
module tb_adder16_s;

  logic        clk;
  logic        reset;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  int tests = 0;
  int fails = 0;

  adder16_s dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operands change at the falling edge, well away from the sampling edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    x   = a;
    y   = b;
    cin = c;
  endtask

  initial begin
    int unsigned s;
    logic [16:0] e;

    reset = 1'b0;
    x     = 16'd100;
    y     = 16'd200;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset", {cout, sum}, 17'h0);

    reset = 1'b1;
    chk("at_release", {cout, sum}, 17'h0);
    @(negedge clk);
    chk("lat_1edge", {cout, sum}, 17'h0);
    @(negedge clk);
    chk("lat_2edge", {cout, sum}, 17'd300);

    drive(16'hFFFF, 16'h0001, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    drive(16'h0000, 16'h0000, 1'b1);
    chk("ffff_p1", {cout, sum}, 17'h10000);
    drive(16'h0, 16'h0, 1'b0);
    chk("ffff_ffff_c1", {cout, sum}, 17'h1FFFF);
    drive(16'h0, 16'h0, 1'b0);
    chk("zero_c1", {cout, sum}, 17'h00001);

    // Ramp: x=100k, y=200k; result for step k visible two drives later.
    for (int k = 0; k < 242; k++) begin
      if (k < 240) drive(16'(100 * k), 16'(200 * k), 1'b0);
      else         drive(16'h0, 16'h0, 1'b0);
      if (k >= 2) begin
        s = 300 * (k - 2);
        e = {(s >= 32'd65536), s[15:0]};
        chk($sformatf("ramp_k%0d", k - 2), {cout, sum}, e);
      end
    end
    drive(16'h0, 16'h0, 1'b0);
    chk("ramp_flush", {cout, sum}, 17'h0);

    drive(16'd1000, 16'd2000, 1'b0);
    drive(16'd3000, 16'd4000, 1'b1);
    drive(16'd5000, 16'd6000, 1'b0);
    chk("pre_rst", {cout, sum}, 17'd3000);
    #2 reset = 1'b0;
    #1 chk("rst_async", {cout, sum}, 17'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {cout, sum}, 17'h0);
    x     = 16'd1;
    y     = 16'd2;
    cin   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_1", {cout, sum}, 17'h0);
    @(negedge clk);
    chk("post_rst_2", {cout, sum}, 17'd3);

    // Operands scrambled between edges must not leak into the results.
    drive(16'd10, 16'd20, 1'b0);
    @(posedge clk);
    #1 begin x = 16'd999; y = 16'd888; cin = 1'b1; end
    #2 begin x = 16'hFFFF; y = 16'hFFFF; cin = 1'b1; end
    drive(16'd30, 16'd40, 1'b1);
    @(posedge clk);
    #1 begin x = 16'd5555; y = 16'd1; cin = 1'b0; end
    drive(16'h0, 16'h0, 1'b0);
    chk("glitch_a", {cout, sum}, 17'd30);
    @(posedge clk);
    #2 begin x = 16'h8000; y = 16'h8000; cin = 1'b1; end
    @(negedge clk);
    chk("glitch_b", {cout, sum}, 17'd71);
    x = 16'h0; y = 16'h0; cin = 1'b0;
    @(negedge clk);
    chk("glitch_c", {cout, sum}, 17'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
